// File: rtl/stack_scan_monitor_pkg.sv
// stack_scan_monitor_pkg: shared stack-bus frame constants, field positions and scan FSM states.
package stack_scan_monitor_pkg;
   localparam logic [3:0]  HDR       = 4'hA;
   localparam logic [15:0] TAIL      = 16'hBEEF;
   localparam int          HDR_LSB   = 28;
   localparam int          POWER_LSB = 24;
   localparam int          ID_LSB    = 20;
   localparam int          NEXT_LSB  = 16;
   localparam int          TAIL_LSB  = 0;
   localparam logic [3:0]  MAX_ID    = 4'd15;
   typedef enum logic [1:0] {ST_IDLE, ST_LISTEN, ST_DONE, ST_ERR} state_t;
endpackage

// File: rtl/stack_frame_decoder.sv
// stack_frame_decoder: splits a stack-bus word into fields and flags well-formed frames.
module stack_frame_decoder
   import stack_scan_monitor_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic        i_valid,
   output logic        o_frame_ok,
   output logic [3:0]  o_power,
   output logic [3:0]  o_id,
   output logic [3:0]  o_next
);
   logic [3:0]  w_hdr;
   logic [15:0] w_tail;
   assign w_hdr   = i_data[HDR_LSB +: 4];
   assign w_tail  = i_data[TAIL_LSB +: 16];
   assign o_power = i_data[POWER_LSB +: 4];
   assign o_id    = i_data[ID_LSB +: 4];
   assign o_next  = i_data[NEXT_LSB +: 4];
   // next must name the following chip, wrapping 15 -> 0 for the last chip
   assign o_frame_ok = i_valid && w_hdr == HDR && w_tail == TAIL && o_next == o_id + 4'd1;
endmodule

// File: rtl/stack_scan_monitor.sv
// stack_scan_monitor: enumerates a chip stack from bus frames into a 16-entry power/presence table.
module stack_scan_monitor
   import stack_scan_monitor_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        div_8_clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   input  logic [3:0]  rd_addr,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic        frame_err,
   output logic [4:0]  chip_count,
   output logic [3:0]  err_count,
   output logic [3:0]  rd_power,
   output logic        rd_present
);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_tmo;
   logic [3:0]  r_exp_id;
   logic [3:0]  r_power [16];
   logic [15:0] r_present;
   logic [4:0]  r_chip_count;
   logic [3:0]  r_err_count;
   logic        r_busy, r_done, r_timeout_err, r_frame_err;
   logic        w_ok, w_listen, w_new, w_retx, w_acc, w_rej, w_clear, w_tmo_hit;
   logic [3:0]  w_power, w_id, w_next;

   stack_frame_decoder u_dec (
      .i_data    (data_in),
      .i_valid   (data_valid),
      .o_frame_ok(w_ok),
      .o_power   (w_power),
      .o_id      (w_id),
      .o_next    (w_next)
   );

   assign w_listen  = r_state == ST_LISTEN;
   assign w_new     = w_listen && w_ok && w_id == r_exp_id;
   assign w_retx    = w_listen && w_ok && w_id == r_exp_id - 4'd1 && r_present[w_id];
   assign w_acc     = w_new || w_retx;
   assign w_rej     = w_listen && data_valid && !w_acc;
   assign w_clear   = !w_listen && start;
   assign w_tmo_hit = w_listen && !w_acc && r_tmo == TMO_LAST;

   always_comb begin
      w_state_nxt = r_state;
      if (w_clear)
         w_state_nxt = ST_LISTEN;
      else if (w_new && w_id == MAX_ID)
         w_state_nxt = ST_DONE;
      else if (w_tmo_hit)
         w_state_nxt = r_chip_count != 5'd0 ? ST_DONE : ST_ERR;
   end

   always_ff @(posedge div_8_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_frame_err   <= 1'b0;
         r_chip_count  <= 5'd0;
         r_err_count   <= 4'd0;
         r_exp_id      <= 4'd1;
         r_tmo         <= 8'd0;
         r_present     <= 16'd0;
         for (int k = 0; k < 16; k++) r_power[k] <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_busy        <= w_state_nxt == ST_LISTEN;
         r_done        <= w_state_nxt == ST_DONE;
         r_timeout_err <= w_state_nxt == ST_ERR;
         if (w_clear) begin
            r_frame_err  <= 1'b0;
            r_chip_count <= 5'd0;
            r_err_count  <= 4'd0;
            r_exp_id     <= 4'd1;
            r_tmo        <= 8'd0;
            r_present    <= 16'd0;
            for (int k = 0; k < 16; k++) r_power[k] <= 4'd0;
         end else begin
            if (w_acc) begin
               r_power[w_id] <= w_power;
               r_tmo         <= 8'd0;
            end else if (w_listen)
               r_tmo <= r_tmo + 8'd1;
            if (w_new) begin
               r_present[w_id] <= 1'b1;
               r_chip_count    <= r_chip_count + 5'd1;
               r_exp_id        <= w_next;
            end
            if (w_rej) begin
               r_frame_err <= 1'b1;
               r_err_count <= r_err_count != 4'hF ? r_err_count + 4'd1 : r_err_count;
            end
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign frame_err   = r_frame_err;
   assign chip_count  = r_chip_count;
   assign err_count   = r_err_count;
   assign rd_power    = r_power[rd_addr];
   assign rd_present  = r_present[rd_addr];
endmodule

// File: doc/stack_scan_monitor.md
STACK_SCAN_MONITOR -- requirements
Module: stack_scan_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: idle cycles in LISTEN before the scan ends, range 2..255.
REQ-002 SHALL have port div_8_clk, input, 1: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a stack scan.
REQ-005 SHALL have port data_in, input, 32: stack bus word, {hdr[31:28], power[27:24], id[23:20], next[19:16], tail[15:0]}.
REQ-006 SHALL have port data_valid, input, 1: strobe; data_in is sampled only when it is high.
REQ-007 SHALL have port rd_addr, input, 4: chip-table read index.
REQ-008 SHALL have port busy, output, 1: high in LISTEN.
REQ-009 SHALL have port done, output, 1: high in DONE.
REQ-010 SHALL have port timeout_err, output, 1: high in ERR.
REQ-011 SHALL have port frame_err, output, 1: sticky flag for any rejected frame in the current scan.
REQ-012 SHALL have port chip_count, output, 5: number of distinct chips accepted.
REQ-013 SHALL have port err_count, output, 4: rejected-frame count, saturating at 15.
REQ-014 SHALL have ports rd_power (output, 4) and rd_present (output, 1): combinational read of table[rd_addr].

Function
REQ-015 SHALL implement FSM states IDLE, LISTEN, DONE and ERR.
REQ-016 IDLE: start -> LISTEN; in the same edge, clear the table, chip_count, err_count, frame_err and tmo_cnt, and set exp_id=1.
REQ-017 DONE/ERR: start SHALL behave as in IDLE; with no start, the state holds and all results stay stable.
REQ-018 LISTEN: start SHALL be ignored.
REQ-019 A frame is valid iff data_valid, hdr==4'hA, tail==16'hBEEF and next==id+1 (4-bit sum).
REQ-020 A valid frame with id==exp_id is a new chip, and SHALL cause the following in one cycle:
- table[id].power<=power
- present<=1
- chip_count+1
- exp_id<=next
- tmo_cnt<=0
REQ-021 A valid frame with id==exp_id-1 and present set is a retransmission, and SHALL cause:
- table[id].power<=power
- tmo_cnt<=0
- no count change and no error
REQ-022 Any other sampled frame, including an invalid one or id==0, SHALL be rejected:
- frame_err<=1
- err_count+1 (saturating)
- tmo_cnt continues
- the FSM stays in LISTEN
REQ-023 A new-chip frame with id==15 (next==0) SHALL be accepted, and LISTEN->DONE on the same edge.
REQ-024 tmo_cnt SHALL increment each LISTEN cycle with no accepted frame.
REQ-025 When tmo_cnt==TIMEOUT_CYC-1 with no accepted frame that cycle:
- chip_count>0 -> DONE
- chip_count==0 -> ERR
REQ-026 An accepted frame in the same cycle as the timeout threshold SHALL take priority: the frame is recorded and tmo_cnt cleared.
REQ-027 Outputs SHALL be registered, except rd_power and rd_present; read latency is 0 cycles.
REQ-028 data_in SHALL be ignored outside LISTEN.

Reset
REQ-029 rst_n low SHALL immediately force the following, including mid-scan:
- FSM to IDLE
- busy, done, timeout_err and frame_err to 0
- chip_count and err_count to 0
- all table entries to power 0, present 0
- exp_id to 1 and tmo_cnt to 0
REQ-030 After rst_n deasserts, the block SHALL take no action until start.

Structure
REQ-031 A shared package SHALL hold:
- HDR 4'hA and TAIL 16'hBEEF
- field bit positions
- the state enum
- MAX_ID=15
REQ-032 Frame decode (hdr/tail/next checks) SHALL be a combinational sub-module stack_frame_decoder, reused by the stack-layer self-test logic.
REQ-033 The table SHALL be 16x5-bit flops (power, present), with entry 0 unused.

Verification
REQ-034 Normal scan: start, then frames A1 12 BEEF, A2 23 BEEF, A3 34 BEEF (power 1, 2, 3), then silence. Required response: done after 64 idle cycles; chip_count=3; rd_addr=2 gives rd_power=2, rd_present=1; frame_err=0.
REQ-035 Retransmit: accept id1 power 1, then resend id1 power 5. Required response: chip_count=1; rd_power[1]=5; err_count=0.
REQ-036 Bad frames: frames with hdr 4'hB, tail BEEE, next!=id+1, and id=3 while exp_id=1. Required response: err_count=4; frame_err=1; chip_count=0; after timeout, ERR with timeout_err=1.
REQ-037 Full stack: new-chip frames id 1..15, the last being AF F0 BEEF. Required response: DONE on the edge that accepts id 15, with no timeout wait; chip_count=15.
REQ-038 Boundary: an accepted frame lands exactly at tmo_cnt==63. Required response: stay in LISTEN. Separately, rst_n pulsed mid-scan: all outputs 0, IDLE, table cleared.
